// File: rtl/pow_if.sv
// pow_if: request/response bundle for pow_unit.
//   start  : request, sampled only while the unit is idle
//   base   : unsigned base operand, captured on an accepted start
//   exp    : unsigned exponent operand, captured on an accepted start
//   busy   : high while the exponentiation is iterating
//   done   : one-cycle pulse, result/ovf valid from this cycle
//   result : base^exp mod 2^RES_W, held until the next done
//   ovf    : true base^exp did not fit in RES_W bits, held with result
interface pow_if #(
  parameter int BASE_W = 8,
  parameter int EXP_W  = 4,
  parameter int RES_W  = 32
);
  logic              start;
  logic [BASE_W-1:0] base;
  logic [EXP_W-1:0]  exp;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  result;
  logic              ovf;

  modport master (output start, base, exp, input busy, done, result, ovf);
  modport slave  (input start, base, exp, output busy, done, result, ovf);
endinterface

// File: rtl/pow_unit.sv
// pow_unit: iterative unsigned exponentiation by square-and-multiply.
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : pow_if slave (start/base/exp in, busy/done/result/ovf out)
//
// state | meaning
// IDLE  | waiting for start, operands captured on accept
// CALC  | one exponent bit consumed per cycle (busy=1)
// DONE  | final acc/aovf copied to the output registers
module pow_unit #(
  parameter int BASE_W = 8,
  parameter int EXP_W  = 4,
  parameter int RES_W  = 32
) (
  input logic  clk,
  input logic  reset,
  pow_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]   b_q, b_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic               bovf_q, bovf_d;
  logic               aovf_q, aovf_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [2*RES_W-1:0] prod_ab, prod_bb;

  // Full-width products so the upper half can flag overflow.
  assign prod_ab = {{RES_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, b_q};
  assign prod_bb = {{RES_W{1'b0}}, b_q} * {{RES_W{1'b0}}, b_q};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    e_d      = e_q;
    bovf_d   = bovf_q;
    aovf_d   = aovf_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = RES_W'(1);
          b_d     = RES_W'(bus.base);
          e_d     = bus.exp;
          bovf_d  = 1'b0;
          aovf_d  = 1'b0;
          state_d = (bus.exp != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        if (e_q[0]) begin
          acc_d = prod_ab[RES_W-1:0];
          // An overflowed b (bovf) means the true multiplicand is already
          // >= 2^RES_W, so the true accumulator overflows too.
          if ((prod_ab[2*RES_W-1:RES_W] != '0) || bovf_q) aovf_d = 1'b1;
        end
        b_d = prod_bb[RES_W-1:0];
        if (prod_bb[2*RES_W-1:RES_W] != '0) bovf_d = 1'b1;
        e_d = e_q >> 1;
        if ((e_q >> 1) == '0) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        ovf_d    = aovf_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      e_q      <= '0;
      bovf_q   <= 1'b0;
      aovf_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      e_q      <= e_d;
      bovf_q   <= bovf_d;
      aovf_q   <= aovf_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_pow_unit.sv
module tb_pow_unit;
  localparam int BW = 8;
  localparam int EW = 4;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pow_if #(.BASE_W(BW), .EXP_W(EW), .RES_W(RW)) bus();
  pow_unit #(.BASE_W(BW), .EXP_W(EW), .RES_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // number of exponent bits = iterations needed
  function automatic int calc_len(int e);
    int l = 0;
    while (e > 0) begin
      l++;
      e = e >> 1;
    end
    return l;
  endfunction

  // exact power, wide enough for 255^15
  function automatic logic [255:0] true_pow(int b, int e);
    logic [255:0] t = 256'd1;
    for (int i = 0; i < e; i++) t = t * 256'(b);
    return t;
  endfunction

  // ---------------- behavioural model (transaction timing) ----------------
  int            n = 0;
  logic          m_active = 1'b0;
  int            m_k = 0;
  int            m_L = 0;
  logic [RW-1:0] m_res_pend = '0;
  logic          m_ovf_pend = 1'b0;
  logic [RW-1:0] cur_res = '0;
  logic          cur_ovf = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic [255:0]  m_t;
  logic          m_acc;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      cur_res  = '0;
      cur_ovf  = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      m_acc    = bus.start && !m_active;
      exp_done = 1'b0;
      if (m_active && n == m_k + m_L + 1) begin
        exp_done = 1'b1;
        cur_res  = m_res_pend;
        cur_ovf  = m_ovf_pend;
        m_active = 1'b0;
      end
      if (m_acc) begin
        m_active   = 1'b1;
        m_k        = n;
        m_L        = calc_len(int'(bus.exp));
        m_t        = true_pow(int'(bus.base), int'(bus.exp));
        m_res_pend = m_t[RW-1:0];
        m_ovf_pend = |m_t[255:RW];
      end
      exp_busy = m_active && (n >= m_k) && (n <= m_k + m_L - 1);
    end
    n++;
  end

  // ---------------- hand-computed literals for the current launch ----------------
  logic          chk_en = 1'b0;
  logic          lit_en = 1'b0;
  logic [RW-1:0] lit_res = '0;
  logic          lit_ovf = 1'b0;
  int            lit_busy = 0;
  int            busy_run = 0;
  int            done_cnt = 0;
  int            to_cnt = 0;
  int            to_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // single compare process, sampled 1 time unit after the active edge
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("busy",   64'(bus.busy),   64'(exp_busy));
      chk("done",   64'(bus.done),   64'(exp_done));
      chk("result", 64'(bus.result), 64'(cur_res));
      chk("ovf",    64'(bus.ovf),    64'(cur_ovf));
      if (reset) busy_run = 0;
      else if (bus.busy) busy_run++;
      if (bus.done) begin
        done_cnt++;
        if (lit_en) begin
          chk("lit_result",  64'(bus.result), 64'(lit_res));
          chk("lit_ovf",     64'(bus.ovf),    64'(lit_ovf));
          chk("lit_busylen", 64'(busy_run),   64'(lit_busy));
          chk("model_pin",   64'(cur_res),    64'(lit_res));
        end
        busy_run = 0;
      end
      if (to_cnt != to_seen) begin
        checks++;
        errors++;
        $display("FAIL timeout: no done within budget, got %0d timeouts expected 0", to_cnt);
        to_seen = to_cnt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_lit(input logic [RW-1:0] r, input logic o, input int bl);
    lit_en   = 1'b1;
    lit_res  = r;
    lit_ovf  = o;
    lit_busy = bl;
  endtask

  task automatic launch(input int b, input int e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = BW'(b);
    bus.exp   = EW'(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == d0) to_cnt++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    @(negedge clk);
    chk_en = 1'b1;
    // start during reset must be ignored
    bus.start = 1'b1;
    bus.base  = 8'd5;
    bus.exp   = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    set_lit(32'd1024, 1'b0, 4);        launch(2, 10);   wait_done(30);
    set_lit(32'd1, 1'b0, 0);           launch(7, 0);    wait_done(30);
    set_lit(32'd0, 1'b0, 3);           launch(0, 5);    wait_done(30);
    set_lit(32'd1, 1'b0, 0);           launch(0, 0);    wait_done(30);
    set_lit(32'd3331788543, 1'b1, 4); launch(255, 15); wait_done(30);
    set_lit(32'd4228250625, 1'b0, 3); launch(255, 4);  wait_done(30);
    set_lit(32'd243, 1'b0, 3);         launch(3, 5);    wait_done(30);
    set_lit(32'd243, 1'b0, 3);         launch(3, 5);

    // second request while busy, with new operands: must be ignored
    bus.start = 1'b1;
    bus.base  = 8'd2;
    bus.exp   = 4'd3;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(30);
    repeat (6) @(negedge clk);

    // reset on the second CALC cycle, then a fresh computation
    set_lit(32'd8, 1'b0, 2);
    launch(3, 15);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    launch(2, 3);
    wait_done(30);

    // start held high: back-to-back relaunches
    set_lit(32'd2, 1'b0, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 8'd2;
    bus.exp   = 4'd1;
    repeat (20) @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pow_unit.md
POW_UNIT -- requirements
Module: pow_unit

Interface
REQ-001 The block SHALL have parameter BASE_W, default 8, meaning the base operand width.
REQ-002 The block SHALL have parameter EXP_W, default 4, meaning the exponent operand width.
REQ-003 The block SHALL have parameter RES_W, default 32, meaning the result width (RES_W >= BASE_W).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 base  input  BASE_W  unsigned base, captured on accepted start.
REQ-008 exp  input  EXP_W  unsigned exponent, captured on accepted start.
REQ-009 busy  output  1  high while a computation is in progress (CALC state).
REQ-010 done  output  1  one-cycle pulse; result/ovf valid from this cycle.
REQ-011 result  output  RES_W  base^exp mod 2^RES_W; held until the next done.
REQ-012 ovf  output  1  high if the true base^exp >= 2^RES_W; held with result.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE + start=1 SHALL load acc=1, b=zero-extended base, e=exp, bovf=0, aovf=0; next state CALC if exp!=0, else DONE.
REQ-015 Each CALC cycle: if e[0], acc <= (acc*b) mod 2^RES_W; b <= (b*b) mod 2^RES_W; e <= e>>1.
REQ-016 Products SHALL be formed at 2*RES_W bits; truncation to RES_W is modulo, never saturation.
REQ-017 aovf SHALL set (sticky) when e[0]=1 and either the acc*b upper RES_W bits are nonzero or bovf=1.
REQ-018 bovf SHALL set (sticky) when the b*b upper RES_W bits are nonzero.
REQ-019 CALC SHALL exit to DONE in the cycle where e>>1 == 0; CALC length = floor(log2(exp))+1 cycles.
REQ-020 DONE SHALL last one cycle: result<=acc, ovf<=aovf registered so both are visible with done=1; next state IDLE.
REQ-021 Latency: start sampled at edge k -> done high in the cycle after edge k+L+1, where L = CALC length (L=0 for exp=0).
REQ-022 start in CALC or DONE SHALL be ignored; operands are not re-sampled; no queuing.
REQ-023 start held high continuously SHALL re-launch on the first IDLE cycle with the then-current base/exp.
REQ-024 0^0 SHALL yield result=1; 0^n (n>0) SHALL yield 0 with ovf=0.
REQ-025 busy SHALL be 1 exactly in CALC; done exactly in DONE; both 0 in IDLE.
REQ-026 Input changes on base/exp outside an accepted start SHALL not affect an ongoing computation.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE and busy=0, done=0, result=0, ovf=0, clearing acc/b/e/bovf/aovf, from any state including mid-CALC.
REQ-028 start asserted in the same cycle as reset SHALL be ignored.
REQ-029 Outputs SHALL be deterministic from the first edge with reset=1; no reliance on initial values.

Verification
REQ-030 base=2, exp=10, start 1 cycle -> busy for 4 cycles, done 5 cycles after start edge, result=1024, ovf=0.
REQ-031 base=7, exp=0 -> done in the cycle after start edge, no busy, result=1, ovf=0; base=0, exp=5 -> result=0, ovf=0.
REQ-032 base=255, exp=15 -> ovf=1, result=(255^15 mod 2^32); base=255, exp=4 -> result=4228250625, ovf=0.
REQ-033 base=3, exp=5 launched, second start with base=2, exp=3 during busy -> single done, result=243; no second done.
REQ-034 base=3, exp=15, reset pulsed on 2nd CALC cycle -> next cycle busy=0, done=0, result=0, ovf=0; new start base=2, exp=3 -> result=8.
REQ-035 start held high for 20 cycles with base=2, exp=1 -> back-to-back computations; done every 3 cycles, result=2.
